// File: rtl/fast_shutter_actuator_model_if.sv
// Fast shutter actuator bundle: controller strobes in, position feedback and status out.
// Latency: wires only, no storage.
// Backpressure: none; the controller drives levels and the model never stalls it.
interface fast_shutter_actuator_model_if;
    logic        drive_pulse_i;
    logic        drive_dir_i;
    logic        jam_i;
    logic        fast_back1_o;
    logic        fast_back2_o;
    logic [2:0]  state_o;
    logic        fault_o;
    logic [31:0] move_cnt_o;

    modport master (
        output drive_pulse_i, drive_dir_i, jam_i,
        input  fast_back1_o, fast_back2_o, state_o, fault_o, move_cnt_o
    );

    modport slave (
        input  drive_pulse_i, drive_dir_i, jam_i,
        output fast_back1_o, fast_back2_o, state_o, fault_o, move_cnt_o
    );
endinterface

// File: rtl/fast_shutter_actuator_model.sv
// Fast shutter actuator model: qualifies drive pulses, simulates stroke travel, jams, timeouts and feedback sensors.
// Latency: state changes on the edge after the accept strobe; feedback decodes from the state register combinationally.
// Backpressure: none; short pulses and accepts that do not change the target are dropped. Optional sensor bounce via FAST_SHUTTER_BOUNCE_EN.
module fast_shutter_actuator_model #(
    parameter int unsigned MIN_PULSE_CYCLES = 4,
    parameter int unsigned TRAVEL_CYCLES    = 100,
    parameter int unsigned TIMEOUT_CYCLES   = 200,
    parameter int unsigned BOUNCE_CYCLES    = 8
) (
    input logic                          clk_i,
    input logic                          rst_n_i,
    fast_shutter_actuator_model_if.slave bus
);

    localparam logic [2:0] ST_CLOSED  = 3'd0;
    localparam logic [2:0] ST_OPENING = 3'd1;
    localparam logic [2:0] ST_OPEN    = 3'd2;
    localparam logic [2:0] ST_CLOSING = 3'd3;
    localparam logic [2:0] ST_FAULT   = 3'd4;

    localparam int QW  = $clog2(MIN_PULSE_CYCLES + 1);
    localparam int TW  = $clog2(TRAVEL_CYCLES + 1);
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [QW-1:0]  MIN_V     = QW'(MIN_PULSE_CYCLES);
    localparam logic [QW-1:0]  MIN_M1_V  = QW'(MIN_PULSE_CYCLES - 1);
    localparam logic [TW-1:0]  TRAVEL_V  = TW'(TRAVEL_CYCLES);
    localparam logic [TOW-1:0] TIMEOUT_V = TOW'(TIMEOUT_CYCLES);

    // Elaboration-time guards on the parameter set.
    if (MIN_PULSE_CYCLES < 1) begin : g_bad_min_pulse
        $error("MIN_PULSE_CYCLES must be at least 1");
    end
    if (TRAVEL_CYCLES < 2 || TRAVEL_CYCLES > 1048575) begin : g_bad_travel
        $error("TRAVEL_CYCLES must be within 2..2^20-1");
    end
    if (TIMEOUT_CYCLES <= TRAVEL_CYCLES) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must exceed TRAVEL_CYCLES");
    end
    if (BOUNCE_CYCLES < 1) begin : g_bad_bounce
        $error("BOUNCE_CYCLES must be at least 1");
    end

    logic [QW-1:0]  qual_q, qual_d;
    logic           accept_q, accept_d;
    logic [2:0]     state_q, state_d;
    logic [TW-1:0]  travel_q, travel_d;
    logic [TOW-1:0] tmo_q, tmo_d;
    logic [31:0]    move_q, move_d;
    logic [TW-1:0]  travel_step;
    logic [TOW-1:0] tmo_step;
    logic           want_open;
    logic           back1, back2;

    // Pulse qualifier: count consecutive high cycles, saturate, and raise a one-cycle accept when the count lands on the minimum.
    always_comb begin
        qual_d   = qual_q;
        accept_d = 1'b0;
        if (!bus.drive_pulse_i) begin
            qual_d = '0;
        end else if (qual_q != MIN_V) begin
            qual_d   = qual_q + 1'b1;
            accept_d = (qual_q == MIN_M1_V);
        end
    end

    // Motion FSM: timeout beats reversal, reversal beats arrival; a zero travel count means already at the far end.
    always_comb begin
        state_d     = state_q;
        travel_d    = travel_q;
        tmo_d       = tmo_q;
        move_d      = move_q;
        want_open   = bus.drive_dir_i;
        travel_step = bus.jam_i ? travel_q : (travel_q - 1'b1);
        tmo_step    = tmo_q + 1'b1;
        case (state_q)
            ST_CLOSED: begin
                if (accept_q && want_open) begin
                    state_d  = ST_OPENING;
                    travel_d = TRAVEL_V;
                    tmo_d    = '0;
                end
            end
            ST_OPEN: begin
                if (accept_q && !want_open) begin
                    state_d  = ST_CLOSING;
                    travel_d = TRAVEL_V;
                    tmo_d    = '0;
                end
            end
            ST_OPENING, ST_CLOSING: begin
                if (tmo_step == TIMEOUT_V) begin
                    state_d  = ST_FAULT;
                    tmo_d    = tmo_step;
                    travel_d = travel_step;
                end else if (accept_q && (want_open != (state_q == ST_OPENING))) begin
                    state_d  = want_open ? ST_OPENING : ST_CLOSING;
                    travel_d = TRAVEL_V - travel_q;
                    tmo_d    = '0;
                end else if (travel_q == '0 || travel_step == '0) begin
                    state_d  = (state_q == ST_OPENING) ? ST_OPEN : ST_CLOSED;
                    travel_d = '0;
                    tmo_d    = '0;
                    move_d   = move_q + 1'b1;
                end else begin
                    travel_d = travel_step;
                    tmo_d    = tmo_step;
                end
            end
            ST_FAULT: begin
                if (accept_q && !bus.jam_i) begin
                    state_d  = want_open ? ST_OPENING : ST_CLOSING;
                    travel_d = TRAVEL_V;
                    tmo_d    = '0;
                end
            end
            default: begin
                state_d  = ST_CLOSED;
                travel_d = '0;
                tmo_d    = '0;
            end
        endcase
    end

    // Core registers; reset abandons any move in progress.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            qual_q   <= '0;
            accept_q <= 1'b0;
            state_q  <= ST_CLOSED;
            travel_q <= '0;
            tmo_q    <= '0;
            move_q   <= '0;
        end else begin
            qual_q   <= qual_d;
            accept_q <= accept_d;
            state_q  <= state_d;
            travel_q <= travel_d;
            tmo_q    <= tmo_d;
            move_q   <= move_d;
        end
    end

`ifdef FAST_SHUTTER_BOUNCE_EN
    localparam int BW = $clog2(BOUNCE_CYCLES + 1);
    localparam logic [BW-1:0] BOUNCE_V   = BW'(BOUNCE_CYCLES);
    localparam logic          BOUNCE_PAR = 1'(BOUNCE_CYCLES % 2);

    logic [BW-1:0] bounce_q, bounce_d;

    // Bounce window: restart on each arrival, run down while at rest, drop it as soon as the shutter leaves rest.
    always_comb begin
        bounce_d = bounce_q;
        if ((state_q == ST_OPENING && state_d == ST_OPEN) ||
            (state_q == ST_CLOSING && state_d == ST_CLOSED)) begin
            bounce_d = BOUNCE_V;
        end else if (state_d != ST_OPEN && state_d != ST_CLOSED) begin
            bounce_d = '0;
        end else if (bounce_q != '0) begin
            bounce_d = bounce_q - 1'b1;
        end
    end

    // Bounce counter register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bounce_q <= '0;
        end else begin
            bounce_q <= bounce_d;
        end
    end
`endif

    // Sensor decode straight from the state register; during a bounce window the arriving sensor alternates starting low.
    always_comb begin
        back1 = 1'b0;
        back2 = 1'b0;
        case (state_q)
            ST_CLOSED: back2 = 1'b1;
            ST_OPEN:   back1 = 1'b1;
            ST_FAULT: begin
                back1 = 1'b1;
                back2 = 1'b1;
            end
            default: begin
                back1 = 1'b0;
                back2 = 1'b0;
            end
        endcase
`ifdef FAST_SHUTTER_BOUNCE_EN
        if (bounce_q != '0) begin
            if (state_q == ST_OPEN) begin
                back1 = bounce_q[0] ^ BOUNCE_PAR;
            end
            if (state_q == ST_CLOSED) begin
                back2 = bounce_q[0] ^ BOUNCE_PAR;
            end
        end
`endif
    end

    assign bus.fast_back1_o = back1;
    assign bus.fast_back2_o = back2;
    assign bus.state_o      = state_q;
    assign bus.fault_o      = (state_q == ST_FAULT);
    assign bus.move_cnt_o   = move_q;

endmodule

// File: tb/tb_fast_shutter_actuator_model.sv
// Bench for the fast shutter actuator model with default parameters (4 / 100 / 200 / 8).
// Stimulus pushes the expected output snapshot and the cycle it must appear on; a negedge
// monitor pops one entry each time the observable outputs change and compares it.
module tb_fast_shutter_actuator_model;

    localparam logic [2:0] S_CLOSED  = 3'd0;
    localparam logic [2:0] S_OPENING = 3'd1;
    localparam logic [2:0] S_OPEN    = 3'd2;
    localparam logic [2:0] S_CLOSING = 3'd3;
    localparam logic [2:0] S_FAULT   = 3'd4;

    typedef struct {
        int          cyc;
        logic        b1;
        logic        b2;
        logic [2:0]  st;
        logic        flt;
        logic [31:0] mc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];
    logic [37:0] prev_snap = '0;
    bit   mon_en = 1'b0;

    fast_shutter_actuator_model_if bus();

    fast_shutter_actuator_model dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [37:0] pack(logic b1, logic b2, logic [2:0] st, logic flt, logic [31:0] mc);
        return {b1, b2, st, flt, mc};
    endfunction

    task automatic push(int c, logic b1, logic b2, logic [2:0] st, logic flt, logic [31:0] mc);
        exp_t e;
        e.cyc = c; e.b1 = b1; e.b2 = b2; e.st = st; e.flt = flt; e.mc = mc;
        expq.push_back(e);
    endtask

    // Arrival at a rest position, including the bounce train when that build option is on.
    task automatic push_arrive(int c, bit open, logic [31:0] mc);
`ifdef FAST_SHUTTER_BOUNCE_EN
        for (int i = 0; i < 8; i++) begin
            logic ph;
            ph = (i % 2 == 1);
            push(c + i, open ? ph : 1'b0, open ? 1'b0 : ph, open ? S_OPEN : S_CLOSED, 1'b0, mc);
        end
`else
        push(c, open, !open, open ? S_OPEN : S_CLOSED, 1'b0, mc);
`endif
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(int len, logic dir);
        bus.drive_dir_i   = dir;
        bus.drive_pulse_i = 1'b1;
        tick(len);
        bus.drive_pulse_i = 1'b0;
    endtask

    task automatic check_now(string name, logic b1, logic b2, logic [2:0] st, logic flt, logic [31:0] mc);
        logic [37:0] got, want;
        got  = pack(bus.fast_back1_o, bus.fast_back2_o, bus.state_o, bus.fault_o, bus.move_cnt_o);
        want = pack(b1, b2, st, flt, mc);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got back=%b%b state=%0d fault=%b moves=%0d, want back=%b%b state=%0d fault=%b moves=%0d",
                     name, got[37], got[36], got[35:33], got[32], got[31:0], b1, b2, st, flt, mc);
        end
    endtask

    // Monitor: every change of the observable outputs must match the next expected entry, cycle included.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [37:0] snap;
            snap = pack(bus.fast_back1_o, bus.fast_back2_o, bus.state_o, bus.fault_o, bus.move_cnt_o);
            if (snap !== prev_snap) begin
                prev_snap = snap;
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: cyc=%0d back=%b%b state=%0d fault=%b moves=%0d, no change expected",
                             cyc, snap[37], snap[36], snap[35:33], snap[32], snap[31:0]);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    if (e.cyc != cyc || snap !== pack(e.b1, e.b2, e.st, e.flt, e.mc)) begin
                        errors++;
                        $display("FAIL output_change: got cyc=%0d back=%b%b state=%0d fault=%b moves=%0d, want cyc=%0d back=%b%b state=%0d fault=%b moves=%0d",
                                 cyc, snap[37], snap[36], snap[35:33], snap[32], snap[31:0],
                                 e.cyc, e.b1, e.b2, e.st, e.flt, e.mc);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int n;
        int r;
        bus.drive_pulse_i = 1'b0;
        bus.drive_dir_i   = 1'b0;
        bus.jam_i         = 1'b0;
        rst_n             = 1'b0;
        tick(3);
        check_now("reset_state", 1'b0, 1'b1, S_CLOSED, 1'b0, 32'd0);
        prev_snap = pack(1'b0, 1'b1, S_CLOSED, 1'b0, 32'd0);
        mon_en    = 1'b1;
        rst_n     = 1'b1;
        tick(2);

        // Open: transit one cycle after the accept, arrival 100 cycles later.
        n = cyc;
        push(n + 5, 1'b0, 1'b0, S_OPENING, 1'b0, 32'd0);
        push_arrive(n + 105, 1'b1, 32'd1);
        pulse(4, 1'b1);
        tick(120);

        // Three-cycle pulse is too short: nothing happens.
        pulse(3, 1'b0);
        tick(10);

        // Ten-cycle pulse: one accept only; flipping dir after the accept must not reverse.
        n = cyc;
        push(n + 5, 1'b0, 1'b0, S_CLOSING, 1'b0, 32'd1);
        push_arrive(n + 105, 1'b0, 32'd2);
        bus.drive_dir_i   = 1'b0;
        bus.drive_pulse_i = 1'b1;
        tick(6);
        bus.drive_dir_i   = 1'b1;
        tick(4);
        bus.drive_pulse_i = 1'b0;
        tick(120);

        // Short open pulse in CLOSED is ignored.
        pulse(3, 1'b1);
        tick(10);

        // Reversal after 40 cycles of opening travel: 40 cycles back to CLOSED.
        n = cyc;
        push(n + 5,  1'b0, 1'b0, S_OPENING, 1'b0, 32'd2);
        push(n + 46, 1'b0, 1'b0, S_CLOSING, 1'b0, 32'd2);
        push_arrive(n + 86, 1'b0, 32'd3);
        pulse(4, 1'b1);
        tick(37);
        pulse(4, 1'b0);
        tick(60);

        // Jammed opening times out into FAULT after 200 transit cycles.
        bus.jam_i = 1'b1;
        n = cyc;
        push(n + 5,   1'b0, 1'b0, S_OPENING, 1'b0, 32'd3);
        push(n + 205, 1'b1, 1'b1, S_FAULT,   1'b1, 32'd3);
        pulse(4, 1'b1);
        tick(210);

        // Accept while still jammed is ignored in FAULT.
        pulse(4, 1'b0);
        tick(10);

        // Clearing the jam lets a close command leave FAULT with full travel.
        bus.jam_i = 1'b0;
        n = cyc;
        push(n + 5, 1'b0, 1'b0, S_CLOSING, 1'b0, 32'd3);
        push_arrive(n + 105, 1'b0, 32'd4);
        pulse(4, 1'b0);
        tick(120);

        // Open again, then start closing and reset 60 cycles into the stroke.
        n = cyc;
        push(n + 5, 1'b0, 1'b0, S_OPENING, 1'b0, 32'd4);
        push_arrive(n + 105, 1'b1, 32'd5);
        pulse(4, 1'b1);
        tick(120);

        n = cyc;
        push(n + 5, 1'b0, 1'b0, S_CLOSING, 1'b0, 32'd5);
        pulse(4, 1'b0);
        tick(61);
        push(cyc, 1'b0, 1'b1, S_CLOSED, 1'b0, 32'd0);
        rst_n = 1'b0;
        #1;
        check_now("async_reset_mid_close", 1'b0, 1'b1, S_CLOSED, 1'b0, 32'd0);

        // Pulse already high at reset release counts from the first edge after release.
        bus.drive_dir_i   = 1'b1;
        bus.drive_pulse_i = 1'b1;
        tick(2);
        rst_n = 1'b1;
        r = cyc;
        push(r + 5, 1'b0, 1'b0, S_OPENING, 1'b0, 32'd0);
        push_arrive(r + 105, 1'b1, 32'd1);
        tick(6);
        bus.drive_pulse_i = 1'b0;
        tick(120);

        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations: got %0d entries left, want 0 (next at cyc %0d)",
                     expq.size(), expq[0].cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fast_shutter_actuator_model.md
FAST_SHUTTER_ACTUATOR_MODEL -- requirements
Module: fast_shutter_actuator_model

Interface
REQ-001 Parameter MIN_PULSE_CYCLES, default 4: consecutive high cycles of drive_pulse_i that qualify one actuation command.
REQ-002 Parameter TRAVEL_CYCLES, default 100: full-stroke travel time in clocks; legal range 2..2^20-1.
REQ-003 Parameter TIMEOUT_CYCLES, default 200: transit cycles allowed before fault; SHALL exceed TRAVEL_CYCLES.
REQ-004 Parameter BOUNCE_CYCLES, default 8: feedback bounce length, used only when the bounce macro is defined.
REQ-005 clk_i  input  1  single system clock; all logic on its rising edge.
REQ-006 rst_n_i  input  1  asynchronous, active-low reset.
REQ-007 drive_pulse_i  input  1  actuation strobe from the shutter controller.
REQ-008 drive_dir_i  input  1  target position: 1 = open, 0 = close.
REQ-009 jam_i  input  1  fault injection; while high, the mechanism does not advance.
REQ-010 fast_back1_o  output  1  position feedback 1 (open sensor).
REQ-011 fast_back2_o  output  1  position feedback 2 (closed sensor).
REQ-012 state_o  output  3  current state encoding.
REQ-013 fault_o  output  1  high while in FAULT.
REQ-014 move_cnt_o  output  32  count of completed arrivals.

Function
REQ-015 States: CLOSED=0, OPENING=1, OPEN=2, CLOSING=3, FAULT=4; all other encodings SHALL recover to CLOSED.
REQ-016 Pulse qualifier: a counter counts consecutive high cycles of drive_pulse_i, saturates at MIN_PULSE_CYCLES, and clears when the input is low.
REQ-017 Accept strobe: asserted for exactly one cycle when the counter reaches MIN_PULSE_CYCLES; drive_dir_i is sampled in that cycle; shorter pulses are ignored.
REQ-018 Accept in CLOSED with dir=1 -> OPENING; accept in OPEN with dir=0 -> CLOSING; an accept toward the current rest position SHALL be ignored.
REQ-019 Entering OPENING or CLOSING from rest or FAULT: load the travel counter with TRAVEL_CYCLES and clear the timeout counter.
REQ-020 Travel counter decrements by 1 per cycle when jam_i=0 and holds when jam_i=1; the timeout counter increments on every cycle in transit.
REQ-021 Arrival: when the travel counter reaches 0, OPENING -> OPEN or CLOSING -> CLOSED, and move_cnt_o increments by 1 (wraps 2^32-1 -> 0).
REQ-022 Reversal: an accept in OPENING with dir=0 -> CLOSING, or in CLOSING with dir=1 -> OPENING; the travel counter reloads with TRAVEL_CYCLES minus its current value; the timeout counter clears.
REQ-023 An accept in transit with the same direction SHALL be ignored.
REQ-024 When the timeout counter reaches TIMEOUT_CYCLES before arrival -> FAULT; timeout takes priority over an arrival or accept in the same cycle.
REQ-025 FAULT exit: an accept with jam_i=0 enters OPENING (dir=1) or CLOSING (dir=0) with full travel; an accept with jam_i=1 is ignored.
REQ-026 Feedback decode from the state register, zero added latency: CLOSED -> back1/back2 = 0/1; OPEN -> 1/0; OPENING or CLOSING -> 0/0; FAULT -> 1/1.
REQ-027 The state transition takes effect on the clock edge following the accept strobe.

Reset
REQ-028 rst_n_i low asynchronously forces: state CLOSED; back1/back2 = 0/1; fault_o=0; move_cnt_o=0; qualifier, travel, timeout and bounce counters = 0.
REQ-029 Reset asserted mid-transit abandons the move without incrementing move_cnt_o.
REQ-030 After reset release, a pulse already high is counted from the first clock edge following release.

Configuration
REQ-031 Macro FAST_SHUTTER_BOUNCE_EN defined: on each arrival, the arriving sensor output toggles every cycle for BOUNCE_CYCLES cycles, starting low, then settles to the REQ-026 value. The opposite sensor stays 0, and move_cnt_o increments at arrival.
REQ-032 Macro FAST_SHUTTER_BOUNCE_EN undefined: no bounce logic is present, and feedback follows REQ-026 exactly.

Verification (MIN_PULSE=4, TRAVEL=100, TIMEOUT=200)
REQ-033 Reset, then a 4-cycle pulse with dir=1 -> back=00 one cycle after the accept; back=10 and move_cnt_o=1 exactly 100 cycles later.
REQ-034 A 3-cycle pulse with dir=1 in CLOSED -> no state change, back stays 01; a 10-cycle pulse produces exactly one accept.
REQ-035 Open started, then a dir=0 accept 40 cycles into OPENING -> CLOSING; back=01 after 40 more cycles; move_cnt_o=1.
REQ-036 jam_i held high during OPENING -> FAULT after 200 transit cycles, with back=11 and fault_o=1. Then a dir=0 pulse with jam_i=0 -> CLOSING, and back=01 100 cycles later.
REQ-037 rst_n_i pulsed low 60 cycles into CLOSING -> back=01, state_o=0 and move_cnt_o=0 immediately, without waiting for a clock edge.
REQ-038 With FAST_SHUTTER_BOUNCE_EN defined, arrival at OPEN -> back1 toggles 0,1,0,1,... for 8 cycles, then holds 1; back2 stays 0.
